// File: rtl/ser_tx_arb.sv
// Two-requester round-robin arbiter feeding an 8N1 serial transmitter.
// One byte per frame; the loser of a tie goes first on the next one.
module ser_tx_arb #(
    parameter int CLKS_PER_BIT = 41667
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic       ser_tx,
    output logic       busy,
    output logic       last_grant
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          last_q;

    logic          sel_d;
    logic          open_d;
    logic          cnt_zero;

    // Tie goes to whoever was not served last; otherwise the lone requester.
    assign sel_d      = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    assign open_d     = rst_n & (state_q == IDLE);
    assign req0_ready = open_d & req0_valid & ~sel_d;
    assign req1_ready = open_d & req1_valid & sel_d;

    assign cnt_zero   = (cnt_q == '0);
    assign ser_tx     = tx_q;
    assign busy       = (state_q != IDLE);
    assign last_grant = last_q;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            last_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (req0_ready | req1_ready) begin
                        state_q <= START;
                        shift_q <= req1_ready ? req1_data : req0_data;
                        last_q  <= req1_ready;
                        cnt_q   <= CNT_MAX;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_zero) begin
                        state_q <= DATA;
                        cnt_q   <= CNT_MAX;
                        bit_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_zero) begin
                        cnt_q <= CNT_MAX;
                        bit_q <= bit_q + 3'd1;
                        // Index wrap 7->0 marks the last data bit.
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (cnt_zero) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_tx_arb.sv
// Bench for ser_tx_arb: directed requests, queued expected frames,
// and a line monitor that decodes and checks every frame it sees.
module tb_ser_tx_arb;

    localparam int CPB = 4;

    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic [7:0] req0_data;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req1_data;
    logic       req1_valid;
    logic       req1_ready;
    logic       ser_tx;
    logic       busy;
    logic       last_grant;

    typedef struct {
        logic [7:0] data;
        logic       grant;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int hs_prev = 0;
    int nr0 = 0;
    int nr1 = 0;
    bit mon_active = 1'b0;
    int mcyc = 0;
    int ferr = 0;
    logic [7:0] got;

    ser_tx_arb #(.CLKS_PER_BIT(CPB)) dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .req0_data (req0_data),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req1_data (req1_data),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .ser_tx    (ser_tx),
        .busy      (busy),
        .last_grant(last_grant)
    );

    always #5 clk_50m = ~clk_50m;

    always @(posedge clk_50m) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_50m) begin
        #1;
        if (req0_ready) nr0++;
        if (req1_ready) nr1++;
    end

    // Line monitor: frames start on the first busy cycle after a handshake.
    always @(negedge clk_50m) begin
        int bp;
        logic eb;
        if (!rst_n) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    mon_active = 1'b1;
                    mcyc = 0;
                    ferr = 0;
                    got = 8'h00;
                    chk("frame_grant", int'(last_grant), int'(cur.grant));
                end
            end
            if (mon_active) begin
                if (mcyc < 10 * CPB) begin
                    bp = mcyc / CPB;
                    if (bp == 0) eb = 1'b0;
                    else if (bp == 9) eb = 1'b1;
                    else eb = cur.data[bp-1];
                    if (ser_tx !== eb || busy !== 1'b1) ferr++;
                    if (mcyc % CPB == CPB / 2 && bp >= 1 && bp <= 8)
                        got[bp-1] = ser_tx;
                    if (mcyc == 10 * CPB - 1) begin
                        chk("frame_bits", ferr, 0);
                        chk("frame_byte", int'(got), int'(cur.data));
                    end
                end else begin
                    chk("frame_len", int'(busy), 0);
                    mon_active = 1'b0;
                end
                mcyc++;
            end
        end
    end

    task automatic wait_hs(output int who);
        int n;
        n = 0;
        forever begin
            #1;
            if (req0_ready || req1_ready || n >= 300) break;
            @(negedge clk_50m);
            n++;
        end
        who = -1;
        if (req0_ready) who = 0;
        else if (req1_ready) who = 1;
        else chk("hs_timeout", 0, 1);
        hs_prev = hs_cyc;
        hs_cyc = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || mon_active || sb.size() != 0) && n < 600) begin
            @(negedge clk_50m);
            #1;
            n++;
        end
        if (n >= 600) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int who;
        int bad;
        rst_n = 1'b0;
        req0_data = 8'h49;
        req1_data = 8'h73;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) @(negedge clk_50m);
        #1;
        chk("rst_tx", int'(ser_tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rdy0", int'(req0_ready), 0);
        chk("rst_rdy1", int'(req1_ready), 0);
        chk("rst_grant", int'(last_grant), 1);

        @(negedge clk_50m);
        rst_n = 1'b1;
        #1;
        chk("first_rdy0", int'(req0_ready), 1);
        chk("first_rdy1", int'(req1_ready), 0);

        // Both requesters held valid for four frames.
        for (int k = 0; k < 4; k++) begin
            wait_hs(who);
            chk($sformatf("rr_order%0d", k), who, k % 2);
            if (k > 0) chk("rr_period", hs_cyc - hs_prev, 41);
            sb.push_back('{(k % 2) ? 8'h73 : 8'h49, 1'(k % 2)});
            @(negedge clk_50m);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
        chk("rdy0_pulses", nr0, 2);
        chk("rdy1_pulses", nr1, 2);

        // Single byte from requester 0.
        req0_data = 8'h41;
        req0_valid = 1'b1;
        wait_hs(who);
        chk("single_who", who, 0);
        sb.push_back('{8'h41, 1'b0});
        @(negedge clk_50m);
        req0_valid = 1'b0;
        wait_idle();

        // Requests during a frame: one withdrawn, one held.
        req1_data = 8'h5A;
        req1_valid = 1'b1;
        wait_hs(who);
        chk("busy_who", who, 1);
        sb.push_back('{8'h5A, 1'b1});
        @(negedge clk_50m);
        req1_valid = 1'b0;
        req0_data = 8'h33;
        req0_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            #1;
            if (req0_ready) bad++;
            @(negedge clk_50m);
        end
        req0_valid = 1'b0;
        chk("busy_rdy_low", bad, 0);
        repeat (15) @(negedge clk_50m);
        req0_data = 8'hC3;
        req0_valid = 1'b1;
        wait_hs(who);
        chk("held_who", who, 0);
        chk("held_period", hs_cyc - hs_prev, 41);
        sb.push_back('{8'hC3, 1'b0});
        @(negedge clk_50m);
        req0_valid = 1'b0;
        wait_idle();

        // Reset during data bit 3 of 0xA5, then a clean frame.
        req0_data = 8'hA5;
        req0_valid = 1'b1;
        wait_hs(who);
        chk("abort_who", who, 0);
        sb.push_back('{8'hA5, 1'b0});
        @(negedge clk_50m);
        req0_valid = 1'b0;
        repeat (17) @(posedge clk_50m);
        #1;
        chk("pre_abort_tx", int'(ser_tx), 0);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", int'(ser_tx), 1);
        chk("abort_busy", int'(busy), 0);
        repeat (2) @(negedge clk_50m);
        rst_n = 1'b1;
        #1;
        chk("abort_grant", int'(last_grant), 1);
        req1_data = 8'h0D;
        req1_valid = 1'b1;
        wait_hs(who);
        chk("after_abort_who", who, 1);
        sb.push_back('{8'h0D, 1'b1});
        @(negedge clk_50m);
        req1_valid = 1'b0;
        wait_idle();

        repeat (5) @(negedge clk_50m);
        chk("no_ghost_busy", int'(busy), 0);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
